// File: rtl/read_batch_loader.sv
// read_batch_loader: forwards a header-sized batch of host lines to the read RAM and reports completion or error
module read_batch_loader #(
  parameter int CL = 512,
  parameter int MAX_READ = 256,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          host_valid,
  input  logic [CL-1:0] host_data,
  output logic          host_ready,
  output logic          load_valid,
  output logic [CL-1:0] load_data,
  output logic [8:0]    batch_size,
  input  logic          load_done,
  output logic [1:0]    line_phase,
  output logic          loader_busy,
  output logic          loader_done,
  output logic          loader_err
);
  localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, DATA = 3'd2, WAIT_DONE = 3'd3, DONE = 3'd4, ERR = 3'd5;
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  logic [2:0] state;
  logic [10:0] line_cnt;
  logic [8:0] read_cnt, n;
  logic [TW-1:0] timer;
  logic accept, hdr_bad, last_line;
  always_comb begin
    host_ready = (state == HDR) || (state == DATA && !load_done);
    accept = host_valid && host_ready;
    n = host_data[8:0];
    hdr_bad = (n == 9'd0) || ({1'b0, n} > 10'(MAX_READ));
    line_phase = line_cnt[1:0];
    last_line = (line_phase == 2'd3) && (read_cnt == batch_size - 9'd1);
    loader_busy = (state == HDR) || (state == DATA) || (state == WAIT_DONE);
    loader_done = state == DONE;
    loader_err = state == ERR;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      line_cnt <= '0;
      read_cnt <= '0;
      timer <= '0;
      batch_size <= '0;
      load_valid <= 1'b0;
      load_data <= '0;
    end else begin
      load_valid <= state == DATA && accept;
      if (state == DATA && accept) load_data <= host_data;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= HDR;
          batch_size <= '0;
          line_cnt <= '0;
          read_cnt <= '0;
          timer <= '0;
        end
        HDR: if (accept) begin
          state <= hdr_bad ? ERR : DATA;
          if (!hdr_bad) batch_size <= n;
        end
        DATA: if (load_done) state <= ERR;
          else if (accept) begin
            line_cnt <= line_cnt + 11'd1;
            if (line_phase == 2'd3) read_cnt <= read_cnt + 9'(read_cnt != 9'd256);
            if (last_line) begin
              state <= WAIT_DONE;
              timer <= '0;
            end
          end
        WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (load_done) state <= DONE;
          else if (timer == TW'(DONE_TIMEOUT - 1)) state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_read_batch_loader.sv
// tb_read_batch_loader: directed vector table plus hand-written batch sequences against a read RAM model
module tb_read_batch_loader;
  localparam int CL = 512;
  logic clk, reset_n, start, host_valid, host_ready, load_valid, load_done;
  logic [CL-1:0] host_data, load_data;
  logic [8:0] batch_size;
  logic [1:0] line_phase;
  logic loader_busy, loader_done, loader_err;
  logic use_model, ld_man, model_done;
  int ram_cnt, last_idx, n_chk, n_fail;

  read_batch_loader #(.CL(CL), .MAX_READ(256), .DONE_TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .load_valid(load_valid), .load_data(load_data), .batch_size(batch_size),
    .load_done(load_done), .line_phase(line_phase), .loader_busy(loader_busy),
    .loader_done(loader_done), .loader_err(loader_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // read RAM model: counts writes, signals done once it holds 4 lines per read
  always @(posedge clk) begin
    if (!reset_n || start) ram_cnt <= 0;
    else if (load_valid) begin
      ram_cnt <= ram_cnt + 1;
      last_idx <= ram_cnt / 4;
    end
  end
  assign model_done = (batch_size != 9'd0) && (ram_cnt == 4 * int'(batch_size));
  assign load_done = use_model ? model_done : ld_man;

  typedef struct {
    logic st, hv; logic [63:0] d; logic ld;
    logic rdy, lv; logic [63:0] q; logic [8:0] bs; logic [1:0] ph; logic busy, done, err;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CL-1:0] pat(input int i);
    return {16{32'(i) ^ 32'hC0DE_0000}};
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_hdr(input int n);
    host_valid = 1'b1;
    host_data = CL'(n);
    tick();
    host_valid = 1'b0;
  endtask

  task automatic burst(input int cnt, input int base);
    for (int i = 0; i < cnt; i++) begin
      host_valid = 1'b1;
      host_data = pat(base + i);
      tick();
      chk("burst_lv", CL'(load_valid), CL'(1));
      chk("burst_data", load_data, pat(base + i));
      chk("burst_phase", CL'(line_phase), CL'((i + 1) % 4));
    end
    host_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!loader_done && !loader_err && k < 200) begin
      tick();
      k++;
    end
    chk(nm, CL'(loader_done), CL'(1));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, CL'(host_ready), CL'(0));
    chk({nm, "_lv"}, CL'(load_valid), CL'(0));
    chk({nm, "_data"}, load_data, CL'(0));
    chk({nm, "_bs"}, CL'(batch_size), CL'(0));
    chk({nm, "_phase"}, CL'(line_phase), CL'(0));
    chk({nm, "_busy"}, CL'(loader_busy), CL'(0));
    chk({nm, "_done"}, CL'(loader_done), CL'(0));
    chk({nm, "_err"}, CL'(loader_err), CL'(0));
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; start = 1'b0; host_valid = 1'b0; host_data = '0;
    use_model = 1'b0; ld_man = 1'b0;
    tbl[0] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 9'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 64'h1, 1'b0, 1'b1, 1'b0, 64'h0, 9'd1, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 64'hA1, 1'b0, 1'b1, 1'b1, 64'hA1, 9'd1, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 64'hB2, 1'b0, 1'b1, 1'b1, 64'hB2, 9'd1, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 64'hC3, 1'b0, 1'b1, 1'b1, 64'hC3, 9'd1, 2'd3, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 64'hD4, 1'b0, 1'b0, 1'b1, 64'hD4, 9'd1, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'hD4, 9'd1, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'hD4, 9'd1, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'hD4, 9'd1, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'hD4, 9'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    repeat (2) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // n=1 batch, back-to-back lines, then restart
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st; host_valid = tbl[i].hv; host_data = {8{tbl[i].d}}; ld_man = tbl[i].ld;
      tick();
      chk($sformatf("v%0d_ready", i), CL'(host_ready), CL'(tbl[i].rdy));
      chk($sformatf("v%0d_lv", i), CL'(load_valid), CL'(tbl[i].lv));
      chk($sformatf("v%0d_data", i), load_data, {8{tbl[i].q}});
      chk($sformatf("v%0d_bs", i), CL'(batch_size), CL'(tbl[i].bs));
      chk($sformatf("v%0d_phase", i), CL'(line_phase), CL'(tbl[i].ph));
      chk($sformatf("v%0d_busy", i), CL'(loader_busy), CL'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), CL'(loader_done), CL'(tbl[i].done));
      chk($sformatf("v%0d_err", i), CL'(loader_err), CL'(tbl[i].err));
    end
    start = 1'b0; host_valid = 1'b0; ld_man = 1'b0;

    // n=3 with bubbles between every line
    use_model = 1'b1;
    send_hdr(3);
    chk("t2_bs", CL'(batch_size), CL'(3));
    for (int i = 0; i < 12; i++) begin
      host_valid = 1'b1;
      host_data = pat(10 + i);
      tick();
      chk("t2_lv", CL'(load_valid), CL'(1));
      chk("t2_data", load_data, pat(10 + i));
      chk("t2_phase", CL'(line_phase), CL'((i + 1) % 4));
      host_valid = 1'b0;
      tick();
      chk("t2_bubble", CL'(load_valid), CL'(0));
    end
    chk("t2_read_cnt", CL'(dut.read_cnt), CL'(3));
    chk("t2_wait_ready", CL'(host_ready), CL'(0));
    chk("t2_wait_busy", CL'(loader_busy), CL'(1));
    wait_done("t2_done");
    chk("t2_writes", CL'(ram_cnt), CL'(12));

    // illegal headers
    do_start();
    send_hdr(0);
    chk("t3_err0", CL'(loader_err), CL'(1));
    chk("t3_bs0", CL'(batch_size), CL'(0));
    chk("t3_lv0", CL'(load_valid), CL'(0));
    chk("t3_ready0", CL'(host_ready), CL'(0));
    do_start();
    chk("t3_cleared", CL'(loader_err), CL'(0));
    send_hdr(257);
    chk("t3_err257", CL'(loader_err), CL'(1));
    chk("t3_bs257", CL'(batch_size), CL'(0));
    chk("t3_lv257", CL'(load_valid), CL'(0));
    chk("t3_writes", CL'(ram_cnt), CL'(0));

    // load_done withheld: timeout after exactly 64 WAIT_DONE cycles
    use_model = 1'b0; ld_man = 1'b0;
    do_start();
    send_hdr(2);
    burst(8, 100);
    repeat (63) tick();
    chk("t4_err_early", CL'(loader_err), CL'(0));
    chk("t4_busy_early", CL'(loader_busy), CL'(1));
    tick();
    chk("t4_err", CL'(loader_err), CL'(1));
    use_model = 1'b1;
    do_start();
    send_hdr(1);
    burst(4, 200);
    wait_done("t4_recover");

    // load_done on the timeout cycle wins
    use_model = 1'b0; ld_man = 1'b0;
    do_start();
    send_hdr(1);
    burst(4, 300);
    repeat (63) tick();
    ld_man = 1'b1;
    #1;
    chk("tie_pre_done", CL'(loader_done), CL'(0));
    tick();
    chk("tie_done", CL'(loader_done), CL'(1));
    chk("tie_err", CL'(loader_err), CL'(0));
    ld_man = 1'b0;

    // load_done while still in DATA
    do_start();
    send_hdr(2);
    burst(2, 400);
    ld_man = 1'b1;
    #1;
    chk("early_ready", CL'(host_ready), CL'(0));
    tick();
    chk("early_err", CL'(loader_err), CL'(1));
    ld_man = 1'b0;

    // full 256-read batch
    use_model = 1'b1;
    do_start();
    send_hdr(256);
    chk("t5_bs", CL'(batch_size), CL'(256));
    burst(1024, 1000);
    wait_done("t5_done");
    chk("t5_writes", CL'(ram_cnt), CL'(1024));
    chk("t5_last_idx", CL'(last_idx), CL'(255));
    chk("t5_bs_hold", CL'(batch_size), CL'(256));

    // reset in the middle of a batch
    do_start();
    send_hdr(4);
    burst(5, 3000);
    reset_n = 1'b0;
    tick();
    chk_all_zero("t6_reset");
    reset_n = 1'b1;
    tick();
    do_start();
    send_hdr(1);
    burst(4, 4000);
    wait_done("t6_recover");
    chk("t6_writes", CL'(ram_cnt), CL'(4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
